axi_rd_burst_issuer: RTL

AXI4 read-address issuer for the kernel's memory read master. It takes a start address and a transfer length in beats. It splits the transfer into full-length bursts plus a trailing remainder burst, drives the AR channel, and tracks outstanding bursts by counting RLAST handshakes. It pulses done once every burst has been issued and returned. It sits between the kernel control logic and the read-data FIFO/consumer.

---
 rtl/axi_rd_pkg.sv | 13 +
 rtl/rd_outstanding_cnt.sv | 37 +++
 rtl/axi_rd_burst_issuer.sv | 109 ++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
// axi_rd_pkg: shared FSM state type and sizing helpers for the AXI read burst issuer
package axi_rd_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction
    function automatic int burst_step(input int burst_len, input int data_width);
        return burst_len * bytes_per_beat(data_width);
    endfunction
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction
endpackage

// File: rtl/rd_outstanding_cnt.sv
// rd_outstanding_cnt: up/down count of AR bursts awaiting their RLAST
//   clk, rst_n      : clock, async active-low reset
//   inc / dec       : AR handshake / RLAST handshake
//   count           : bursts in flight
//   is_full/is_zero : count at limit / count empty
module rd_outstanding_cnt
    import axi_rd_pkg::*;
#(
    parameter int C_MAX_OUTSTANDING = 16,
    localparam int W = cnt_width(C_MAX_OUTSTANDING)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_full,
    output logic         is_zero
);
    assign is_full = count == W'(C_MAX_OUTSTANDING);
    assign is_zero = count == '0;

    // a stray RLAST on an empty counter saturates at zero rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !dec)
            count <= count + W'(1);
        else if (dec && !inc && !is_zero)
            count <= count - W'(1);
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && is_zero))
        else $error("rd_outstanding_cnt: r_last_hs with no burst outstanding");
`endif
endmodule

// File: rtl/axi_rd_burst_issuer.sv
// axi_rd_burst_issuer: splits a beat-count transfer into AXI4 read bursts and tracks their completion
//   clk, rst_n                            : clock, async active-low reset
//   ctrl_start/addr/xfer_beats            : transfer request (accepted only in IDLE)
//   ctrl_busy, ctrl_done                  : transfer in progress / one-cycle completion pulse
//   m_arvalid/arready/araddr/arlen        : AR channel (registered outputs)
//   r_last_hs                             : one pulse per RLAST handshake
module axi_rd_burst_issuer
    import axi_rd_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_WIDTH      = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_XFER_WIDTH-1:0] ctrl_xfer_beats,
    output logic                    ctrl_busy,
    output logic                    ctrl_done,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [C_ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]              m_arlen,
    input  logic                    r_last_hs
);
    localparam int LB = $clog2(C_BURST_LEN);
    localparam int BW = C_XFER_WIDTH - LB + 1;
    localparam int CW = cnt_width(C_MAX_OUTSTANDING);
    localparam logic [C_ADDR_WIDTH-1:0] STEP = C_ADDR_WIDTH'(burst_step(C_BURST_LEN, C_DATA_WIDTH));
    localparam logic [7:0] FULL_LEN = 8'(C_BURST_LEN - 1);

    state_t        state, state_next;
    logic [BW-1:0] bursts_left, start_bursts;
    logic [LB-1:0] last_len, start_last, last_m1, start_m1;
    logic [CW-1:0] count;
    logic          is_full, is_zero, hs, full_after, drain_empty, arvalid_next;

    assign hs           = m_arvalid & m_arready;
    assign start_last   = ctrl_xfer_beats[LB-1:0];
    assign start_bursts = BW'(ctrl_xfer_beats >> LB) + BW'(start_last != '0);
    // a zero remainder wraps to C_BURST_LEN-1, i.e. the final burst is a full one
    assign start_m1     = start_last - LB'(1);
    assign last_m1      = last_len - LB'(1);
    assign ctrl_busy    = state != IDLE;

    // fullness and emptiness as they will be after this edge, so throttle and drain react without a bubble
    assign full_after   = hs ? (r_last_hs ? is_full : count == CW'(C_MAX_OUTSTANDING - 1))
                             : (is_full & ~r_last_hs);
    assign drain_empty  = r_last_hs ? count == CW'(1) : is_zero;
    // a stalled request is held; otherwise raise valid only if a burst remains and there is room
    assign arvalid_next = (m_arvalid & ~m_arready) |
                          (state == ISSUE && (bursts_left - BW'(hs)) != '0 && !full_after);

    rd_outstanding_cnt #(.C_MAX_OUTSTANDING(C_MAX_OUTSTANDING)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (hs),
        .dec     (r_last_hs),
        .count   (count),
        .is_full (is_full),
        .is_zero (is_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_start) state_next = (ctrl_xfer_beats == '0) ? DONE : ISSUE;
            ISSUE:   if (hs && bursts_left == BW'(1)) state_next = DRAIN;
            DRAIN:   if (drain_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // m_araddr/m_arlen change only at start or on a handshake, so they stay stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_arlen     <= '0;
            bursts_left <= '0;
            last_len    <= '0;
            ctrl_done   <= 1'b0;
        end else begin
            m_arvalid <= arvalid_next;
            ctrl_done <= state == DONE;
            if (state == IDLE && ctrl_start) begin
                m_araddr    <= ctrl_addr;
                bursts_left <= start_bursts;
                last_len    <= start_last;
                m_arlen     <= (start_bursts == BW'(1)) ? 8'(start_m1) : FULL_LEN;
            end else if (hs) begin
                m_araddr    <= m_araddr + STEP;
                bursts_left <= bursts_left - BW'(1);
                m_arlen     <= (bursts_left == BW'(2)) ? 8'(last_m1) : FULL_LEN;
            end
        end
    end
endmodule
